// File: rtl/pipe_muldiv_if.sv
// Handshake/data bundle between the EXE stage and the multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface pipe_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             rd_hilo;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             stall;

   modport master (
      output start, op, a, b, rd_hilo, wr_hi, wr_lo, wdata,
      input  hi, lo, busy, done, stall
   );

   modport slave (
      input  start, op, a, b, rd_hilo, wr_hi, wr_lo, wdata,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Every operation takes exactly
// WIDTH iterations; signs are stripped at issue and re-applied on writeback.
module pipe_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic          clock,
   input logic          reset,
   pipe_muldiv_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   // Datapath state: r holds {remainder/acc, quotient/multiplier}.
   logic [1:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   r_q, r_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic                 dz_q, dz_d;

   logic                 sgn_in;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   r_step;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     res_hi, res_lo;

   function automatic logic [WIDTH-1:0] abs_op(input logic signed [WIDTH-1:0] v,
                                                input logic sgn);
      return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   assign sgn_in = ~bus.op[0];
   assign a_abs  = abs_op(bus.a, sgn_in);
   assign b_abs  = abs_op(bus.b, sgn_in);

   // One iteration step and the sign-corrected writeback values.
   always_comb begin
      mul_sum  = {1'b0, r_q[2*WIDTH-1:WIDTH]} + (r_q[0] ? {1'b0, m_q} : '0);
      rem_sh   = r_q[2*WIDTH-1:WIDTH-1];
      div_diff = rem_sh - {1'b0, m_q};
      if (op_q[1]) begin
         if (div_diff[WIDTH])
            r_step = {rem_sh[WIDTH-1:0], r_q[WIDTH-2:0], 1'b0};
         else
            r_step = {div_diff[WIDTH-1:0], r_q[WIDTH-2:0], 1'b1};
      end else begin
         r_step = {mul_sum, r_q[WIDTH-1:1]};
      end
      prod = neg_2w(r_step, qneg_q);
      if (!op_q[1]) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (dz_q) begin
         res_hi = a_q;
         res_lo = '1;
      end else begin
         res_hi = neg_w(r_step[2*WIDTH-1:WIDTH], rneg_q);
         res_lo = neg_w(r_step[WIDTH-1:0], qneg_q);
      end
   end

   // Next-state: issue/MTHI/MTLO in IDLE, iterate and write back in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      op_d    = op_q;
      r_d     = r_q;
      m_d     = m_q;
      a_d     = a_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d   = bus.op;
               a_d    = bus.a;
               qneg_d = sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               rneg_d = sgn_in & bus.a[WIDTH-1];
               dz_d   = bus.op[1] & (bus.b == '0);
               if (bus.op[1]) begin
                  m_d = b_abs;
                  r_d = {{WIDTH{1'b0}}, a_abs};
               end else begin
                  m_d = a_abs;
                  r_d = {{WIDTH{1'b0}}, b_abs};
               end
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               // MTHI/MTLO only land when no operation is being issued.
               if (bus.wr_hi) hi_d = bus.wdata;
               if (bus.wr_lo) lo_d = bus.wdata;
            end
         end
         RUN: begin
            r_d   = r_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               hi_d    = res_hi;
               lo_d    = res_lo;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and architectural registers; reset aborts any operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Internal operand/partial registers; always reloaded on issue.
   always_ff @(posedge clock) begin
      op_q   <= op_d;
      r_q    <= r_d;
      m_q    <= m_d;
      a_q    <= a_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = done_q;
   assign bus.stall = (state_q == RUN) & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_pipe_muldiv.sv
// Bench for pipe_muldiv: vector table through a result scoreboard plus
// hand-written sequences for MTHI/MTLO, stall, ignored writes and reset.
module tb_pipe_muldiv;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pipe_muldiv_if #(.WIDTH(32)) bus ();

   pipe_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      string       name;
   } vec_t;

   localparam int NV = 13;
   vec_t        vecs[NV];
   logic [63:0] sb[$];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive start for one cycle; returns at the negedge after the issue edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      sb.push_back({ehi, elo});
      @(negedge clock);
      bus.start = 1'b0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
   endtask

   // Called at the negedge where done is expected high.
   task automatic finish_op(input string name, input int busy_cycles);
      logic [63:0] exp;
      check({name, "_busy_cycles"}, busy_cycles, 32);
      check({name, "_done"}, {31'b0, bus.done}, 32'd1);
      check({name, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb.pop_front();
         check({name, "_hi"}, bus.hi, exp[63:32]);
         check({name, "_lo"}, bus.lo, exp[31:0]);
      end
      @(negedge clock);
      check({name, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      bit seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            seen = 1;
            break;
         end
         if (bus.busy) cyc++;
         @(negedge clock);
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         finish_op(name, cyc);
      end
   endtask

   initial begin
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
      vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, "mult_neg7x6"};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
      vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,        "divu_100by7"};
      vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
      vecs[5]  = '{2'b11, 32'd123,      32'd0,        32'd123,      32'hFFFFFFFF, "divu_zero"};
      vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero_neg"};
      vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"};
      vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7byneg2"};
      vecs[9]  = '{2'b00, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, "mult_3xneg1"};
      vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu_by1"};
      vecs[11] = '{2'b00, 32'd0,        32'h12345678, 32'd0,        32'd0,        "mult_zero"};
      vecs[12] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};

      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.a       = '0;
      bus.b       = '0;
      bus.rd_hilo = 1'b0;
      bus.wr_hi   = 1'b0;
      bus.wr_lo   = 1'b0;
      bus.wdata   = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state.
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);

      // MTHI / MTLO in IDLE.
      bus.wr_hi = 1'b1;
      bus.wdata = 32'h1234;
      #1;
      check("mthi_stall", {31'b0, bus.stall}, 32'd0);
      @(negedge clock);
      bus.wr_hi = 1'b0;
      check("mthi_hi", bus.hi, 32'h1234);
      check("mthi_lo_kept", bus.lo, 32'd0);
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h5678;
      @(negedge clock);
      bus.wr_lo = 1'b0;
      check("mtlo_lo", bus.lo, 32'h5678);
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wdata = 32'hAAAA5555;
      @(negedge clock);
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      check("mthilo_hi", bus.hi, 32'hAAAA5555);
      check("mthilo_lo", bus.lo, 32'hAAAA5555);

      // Vector table.
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
         wait_done(vecs[i].name);
      end

      // MTHI issued together with start is dropped; hi keeps old value in RUN.
      bus.wr_hi = 1'b1;
      bus.wdata = 32'hFFFF0000;
      issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15);
      check("start_wr_hi_dropped", bus.hi, vecs[NV-1].ehi);
      wait_done("multu_3x5");

      // Stall and ignored inputs during RUN.
      begin
         int  cyc = 0;
         int  c = 1;
         bit  seen = 0;
         bit  stall_bad = 0;
         bit  hilo_bad = 0;
         issue(2'b00, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD);
         for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
               seen = 1;
               break;
            end
            if (bus.busy) cyc++;
            if (c >= 6 && bus.stall !== 1'b1) stall_bad = 1;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd15) hilo_bad = 1;
            if (c == 5) bus.rd_hilo = 1'b1;
            if (c == 10) begin
               bus.start = 1'b1;
               bus.op    = 2'b11;
               bus.a     = 32'd99;
               bus.b     = 32'd9;
               bus.wr_hi = 1'b1;
               bus.wdata = 32'hDEADBEEF;
            end
            if (c == 13) begin
               bus.start = 1'b0;
               bus.wr_hi = 1'b0;
            end
            c++;
            @(negedge clock);
         end
         check("run_stall_held", {31'b0, stall_bad}, 32'd0);
         check("run_hilo_unchanged", {31'b0, hilo_bad}, 32'd0);
         check("stall_released", {31'b0, bus.stall}, 32'd0);
         bus.rd_hilo = 1'b0;
         if (!seen) begin
            check("stall_seq_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
         end else begin
            finish_op("mult_stall", cyc);
         end
      end

      // Reset in the middle of a divide.
      begin
         bit done_bad = 0;
         issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
         repeat (9) @(negedge clock);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         sb.delete();
         check("midrst_hi", bus.hi, 32'd0);
         check("midrst_lo", bus.lo, 32'd0);
         check("midrst_busy", {31'b0, bus.busy}, 32'd0);
         for (int k = 0; k < 35; k++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_bad = 1;
            @(negedge clock);
         end
         check("midrst_no_done", {31'b0, done_bad}, 32'd0);
         issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
         wait_done("multu_after_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_muldiv.md
Name: pipe_muldiv

Overview:
- Iterative multiply/divide unit in the EXE stage of the 5-stage pipelined CPU, beside the ALU.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a stall request that the ID-stage hazard logic ORs into the PC/IF-ID hold signal while a result is pending.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is required to be supported.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue the operation selected by op, with operands a and b.
- op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand: multiplicand or dividend.
- b  in  WIDTH  rt operand: multiplier or divisor.
- rd_hilo  in  1  the instruction in EXE reads HI or LO (MFHI/MFLO).
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdata  in  WIDTH  data for MTHI/MTLO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated.
- stall  out  1  combinational: busy & (start | rd_hilo | wr_hi | wr_lo).

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, counter=0. Reset aborts any in-flight operation and leaves no partial result.
- Two states, IDLE and RUN; busy is 1 exactly when the state is RUN.
- IDLE, start=1:
  - Latch op and |a|, |b|. Absolute values apply to signed ops only; unsigned ops latch raw values.
  - Latch sign flags: quotient/product negative = a[31]^b[31]; remainder negative = a[31]. Both flags are 0 for unsigned ops.
  - Latch div_zero = (b==0) for DIV/DIVU.
  - Set counter=0 and go to RUN.
- RUN:
  - Perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide. Increment the counter.
  - In the cycle with counter==WIDTH-1, the next edge writes hi/lo, sets done=1 for one cycle and returns to IDLE.
- Latency: start sampled at edge T0 gives busy=1 during cycles T0..T32, new hi/lo and done=1 after edge T32, and busy=0 after T32. Exactly 32 cycles for every op, including divide-by-zero.
- Multiply results: {hi,lo} = 64-bit product. For MULT, the result is the two's-complement negation of the unsigned product when the sign flag is set.
- Divide results: lo = quotient, hi = remainder, with signs applied from the latched flags.
- Signed overflow, -2^31 / -1: lo=32'h80000000, hi=0.
- Divide by zero, both DIV and DIVU: lo=32'hFFFFFFFF, hi=a as latched, unmodified.
- Priority in IDLE: start > wr_hi/wr_lo. A same-cycle MTHI/MTLO together with start is dropped.
  - wr_hi and wr_lo together both write wdata.
- In RUN: start, wr_hi, wr_lo and rd_hilo are ignored by the datapath and raise stall. The pipeline holds the instruction, which is re-presented after busy falls.
- hi/lo are read without latency. During RUN they keep their old values; intermediate partial products and remainders stay in internal registers only.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 32 cycles hi=32'hFFFFFFFE, lo=32'h00000001; done is a single-cycle pulse; busy=1 for exactly 32 cycles.
- MULT a=-7 (32'hFFFFFFF9), b=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- Division edge cases:
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
  - DIVU a=123, b=0 -> lo=32'hFFFFFFFF, hi=123, after the full 32-cycle latency.
- Stall behaviour during RUN:
  - Issue MULT, then at cycle 5 assert rd_hilo -> stall=1 through cycle 32, stall=0 after edge T32.
  - start and wr_hi asserted during RUN leave hi/lo unaffected.
  - MTHI wdata=32'h1234 in IDLE -> hi=32'h1234 the next cycle, stall=0.
- Reset at cycle 10 of a DIV -> next cycle hi=0, lo=0, busy=0, done stays 0. A new MULTU 3*4 then gives lo=12, hi=0.
